// File: rtl/bitlet_pe_driver_pkg.sv
// Shared Bitlet word widths and helpers used by the PE driver and its buffer.
package bitlet_pe_driver_pkg;
  localparam int Wid_bin = 16;
  localparam int Wid_exp = 5;
  localparam int Wid_abs = 8;
endpackage

// File: rtl/bitlet_pe_driver_if.sv
// PE-facing port bundle: job setup, activation beats and the result return.
interface bitlet_pe_driver_if #(
  parameter int N_total = 64,
  parameter int N_input = 16
);
  import bitlet_pe_driver_pkg::*;

  logic [$clog2(N_total)-1:0]    pe_N_calculate;
  logic                          pe_flush;
  logic [N_total-1:0]            pe_Wsig_vec;
  logic [N_total*Wid_exp-1:0]    pe_Wexp_vec;
  logic [N_total*Wid_abs-1:0]    pe_Wabs_vec;
  logic                          pe_Abin_vld;
  logic [N_input*Wid_bin-1:0]    pe_Abin_vec;
  logic                          pe_res_vld;
  logic [Wid_bin-1:0]            pe_res;

  modport master (
    output pe_N_calculate, pe_flush, pe_Wsig_vec, pe_Wexp_vec, pe_Wabs_vec,
           pe_Abin_vld, pe_Abin_vec,
    input  pe_res_vld, pe_res
  );

  modport slave (
    input  pe_N_calculate, pe_flush, pe_Wsig_vec, pe_Wexp_vec, pe_Wabs_vec,
           pe_Abin_vld, pe_Abin_vec,
    output pe_res_vld, pe_res
  );
endinterface

// File: rtl/bitlet_act_buffer.sv
// Activation register file: one element write port, one registered N_input-wide slice read.
module bitlet_act_buffer
  import bitlet_pe_driver_pkg::*;
#(
  parameter  int N_total = 64,
  parameter  int N_input = 16,
  localparam int AW      = $clog2(N_total)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [AW-1:0]                    wr_addr,
  input  logic [Wid_bin-1:0]               wr_data,
  input  logic                             rd_en,
  input  logic [AW-1:0]                    rd_beat,
  output logic [N_input-1:0][Wid_bin-1:0]  rd_data_o
);
  logic [N_total-1:0][Wid_bin-1:0] mem_q;
  logic [AW-1:0]                   base;

  assign base = AW'(int'(rd_beat) * N_input);

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  for (genvar g = 0; g < N_input; g++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst)        rd_data_o[g] <= '0;
      else if (rd_en) rd_data_o[g] <= mem_q[base + AW'(g)];
    end
  end
endmodule

// File: rtl/bitlet_pe_driver.sv
// Host-side sequencer for one Bitlet PE: flush, stream activation beats, wait for result or timeout.
module bitlet_pe_driver
  import bitlet_pe_driver_pkg::*;
#(
  parameter  int N_total = 64,
  parameter  int N_input = 16,
  parameter  int TIMEOUT = 1023,
  localparam int AW      = $clog2(N_total),
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       act_wr_en,
  input  logic [AW-1:0]              act_wr_addr,
  input  logic [Wid_bin-1:0]         act_wr_data,
  input  logic                       start,
  input  logic [AW-1:0]              start_ncalc,
  input  logic [N_total-1:0]         wgt_sig_vec,
  input  logic [N_total*Wid_exp-1:0] wgt_exp_vec,
  input  logic [N_total*Wid_abs-1:0] wgt_abs_vec,
  output logic                       start_rdy,
  output logic                       done,
  output logic [Wid_bin-1:0]         result,
  output logic                       timeout,
  bitlet_pe_driver_if.master         pe
);
  if (N_total % N_input != 0) begin : g_bad_cfg
    $error("bitlet_pe_driver: N_total must be a multiple of N_input");
  end

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_STREAM, S_WAIT} state_e;

  state_e                     state_q;
  logic [AW-1:0]              beat_q, last_q, last_d;
  logic [TW-1:0]              wdog_q;
  logic [AW-1:0]              ncalc_q;
  logic [N_total-1:0]         wsig_q;
  logic [N_total*Wid_exp-1:0] wexp_q;
  logic [N_total*Wid_abs-1:0] wabs_q;
  logic                       rdy_q, flush_q, vld_q, done_q, timeout_q;
  logic [Wid_bin-1:0]         result_q;

  logic                       buf_wr_en, buf_rd_en;
  logic [AW-1:0]              buf_rd_beat;
  logic [N_input-1:0][Wid_bin-1:0] buf_rd_data;

  assign last_d      = AW'(int'(start_ncalc) / N_input);
  assign buf_wr_en   = act_wr_en && (state_q == S_IDLE);
  // Read runs one beat ahead so the slice register lines up with vld_q.
  assign buf_rd_en   = (state_q == S_FLUSH) || (state_q == S_STREAM && beat_q != last_q);
  assign buf_rd_beat = (state_q == S_FLUSH) ? '0 : beat_q + 1'b1;

  bitlet_act_buffer #(.N_total(N_total), .N_input(N_input)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (buf_wr_en),
    .wr_addr   (act_wr_addr),
    .wr_data   (act_wr_data),
    .rd_en     (buf_rd_en),
    .rd_beat   (buf_rd_beat),
    .rd_data_o (buf_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b1;
      flush_q   <= 1'b0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= '0;
      ncalc_q   <= '0;
      wsig_q    <= '0;
      wexp_q    <= '0;
      wabs_q    <= '0;
      beat_q    <= '0;
      last_q    <= '0;
      wdog_q    <= '0;
    end else begin
      flush_q   <= 1'b0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) begin
          ncalc_q <= start_ncalc;
          wsig_q  <= wgt_sig_vec;
          wexp_q  <= wgt_exp_vec;
          wabs_q  <= wgt_abs_vec;
          last_q  <= last_d;
          flush_q <= 1'b1;
          rdy_q   <= 1'b0;
          state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          beat_q  <= '0;
          vld_q   <= 1'b1;
          state_q <= S_STREAM;
        end
        S_STREAM: if (beat_q == last_q) begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end else begin
          beat_q  <= beat_q + 1'b1;
          vld_q   <= 1'b1;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + 1'b1;
          // A result arriving on the expiry cycle still counts as success.
          if (pe.pe_res_vld) begin
            result_q <= pe.pe_res;
            done_q   <= 1'b1;
            rdy_q    <= 1'b1;
            state_q  <= S_IDLE;
          end else if (wdog_q == TW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            rdy_q     <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_rdy         = rdy_q;
  assign done              = done_q;
  assign timeout           = timeout_q;
  assign result            = result_q;
  assign pe.pe_N_calculate = ncalc_q;
  assign pe.pe_flush       = flush_q;
  assign pe.pe_Wsig_vec    = wsig_q;
  assign pe.pe_Wexp_vec    = wexp_q;
  assign pe.pe_Wabs_vec    = wabs_q;
  assign pe.pe_Abin_vld    = vld_q;
  assign pe.pe_Abin_vec    = buf_rd_data;
endmodule

// File: tb/tb_bitlet_pe_driver.sv
// Randomized job-level bench for bitlet_pe_driver against a simple buffer/job model.
module tb_bitlet_pe_driver;
  import bitlet_pe_driver_pkg::*;

  localparam int NT  = 64;
  localparam int NI  = 16;
  localparam int TMO = 8;
  localparam int AW  = $clog2(NT);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  act_wr_en;
  logic [AW-1:0]         act_wr_addr;
  logic [Wid_bin-1:0]    act_wr_data;
  logic                  start;
  logic [AW-1:0]         start_ncalc;
  logic [NT-1:0]         wgt_sig_vec;
  logic [NT*Wid_exp-1:0] wgt_exp_vec;
  logic [NT*Wid_abs-1:0] wgt_abs_vec;
  logic                  start_rdy, done, timeout;
  logic [Wid_bin-1:0]    result;

  bitlet_pe_driver_if #(.N_total(NT), .N_input(NI)) u_if ();

  bitlet_pe_driver #(.N_total(NT), .N_input(NI), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .act_wr_en   (act_wr_en),
    .act_wr_addr (act_wr_addr),
    .act_wr_data (act_wr_data),
    .start       (start),
    .start_ncalc (start_ncalc),
    .wgt_sig_vec (wgt_sig_vec),
    .wgt_exp_vec (wgt_exp_vec),
    .wgt_abs_vec (wgt_abs_vec),
    .start_rdy   (start_rdy),
    .done        (done),
    .result      (result),
    .timeout     (timeout),
    .pe          (u_if.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [Wid_bin-1:0]    ref_buf [NT];
  logic [Wid_bin-1:0]    ref_result;
  logic [NT-1:0]         ref_sig;
  logic [NT*Wid_exp-1:0] ref_exp;
  logic [NT*Wid_abs-1:0] ref_abs;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_weights();
    for (int i = 0; i < NT / 32; i++)          wgt_sig_vec[i*32 +: 32] = $urandom;
    for (int i = 0; i < NT * Wid_exp / 32; i++) wgt_exp_vec[i*32 +: 32] = $urandom;
    for (int i = 0; i < NT * Wid_abs / 32; i++) wgt_abs_vec[i*32 +: 32] = $urandom;
  endtask

  task automatic chk_reset_state();
    chk("rst_flush",  512'(u_if.pe_flush), 512'(0));
    chk("rst_vld",    512'(u_if.pe_Abin_vld), 512'(0));
    chk("rst_vec",    512'(u_if.pe_Abin_vec), 512'(0));
    chk("rst_done",   512'(done), 512'(0));
    chk("rst_tmo",    512'(timeout), 512'(0));
    chk("rst_result", 512'(result), 512'(0));
    chk("rst_ncalc",  512'(u_if.pe_N_calculate), 512'(0));
    chk("rst_wsig",   512'(u_if.pe_Wsig_vec), 512'(0));
    chk("rst_wexp",   512'(u_if.pe_Wexp_vec), 512'(0));
    chk("rst_wabs",   512'(u_if.pe_Wabs_vec), 512'(0));
    chk("rst_rdy",    512'(start_rdy), 512'(1));
  endtask

  task automatic wr(input int addr, input logic [Wid_bin-1:0] data);
    act_wr_en   = 1'b1;
    act_wr_addr = AW'(addr);
    act_wr_data = data;
    tick();
    act_wr_en   = 1'b0;
    ref_buf[addr] = data;
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < NT; i++) wr(i, rnd ? Wid_bin'($urandom) : Wid_bin'(i));
  endtask

  // resp: WAIT cycle index at which the PE answers (-1 = never).
  // lock: poke start/write during beat 0. rst_at: reset during that beat (-1 = none).
  task automatic run_job(input int ncalc, input int resp, input bit lock, input int rst_at);
    int nb;
    logic [NI*Wid_bin-1:0] ev;
    logic [Wid_bin-1:0] rv;
    bit answered;
    nb = (ncalc + NI) / NI;
    rand_weights();
    ref_sig = wgt_sig_vec; ref_exp = wgt_exp_vec; ref_abs = wgt_abs_vec;
    chk("idle_rdy", 512'(start_rdy), 512'(1));
    start = 1'b1;
    start_ncalc = AW'(ncalc);
    tick();
    start = 1'b0;
    rand_weights();
    chk("flush",       512'(u_if.pe_flush), 512'(1));
    chk("flush_vld",   512'(u_if.pe_Abin_vld), 512'(0));
    chk("flush_rdy",   512'(start_rdy), 512'(0));
    chk("ncalc",       512'(u_if.pe_N_calculate), 512'(ncalc));
    tick();
    for (int k = 0; k < nb; k++) begin
      for (int e = 0; e < NI; e++) ev[e*Wid_bin +: Wid_bin] = ref_buf[k*NI + e];
      chk("beat_vld", 512'(u_if.pe_Abin_vld), 512'(1));
      chk("beat_vec", 512'(u_if.pe_Abin_vec), 512'(ev));
      chk("beat_flush", 512'(u_if.pe_flush), 512'(0));
      if (k == 0) begin
        chk("wsig", 512'(u_if.pe_Wsig_vec), 512'(ref_sig));
        chk("wexp", 512'(u_if.pe_Wexp_vec), 512'(ref_exp));
        chk("wabs", 512'(u_if.pe_Wabs_vec), 512'(ref_abs));
      end
      if (lock && k == 0) begin
        start = 1'b1; act_wr_en = 1'b1; act_wr_addr = AW'(5); act_wr_data = 16'h00FF;
      end
      if (rst_at == k) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_result = '0;
        chk_reset_state();
        return;
      end
      tick();
      start = 1'b0; act_wr_en = 1'b0;
    end
    chk("wait_vld", 512'(u_if.pe_Abin_vld), 512'(0));
    answered = 1'b0;
    for (int w = 0; w < TMO && !answered; w++) begin
      chk("wait_done", 512'(done), 512'(0));
      chk("wait_tmo",  512'(timeout), 512'(0));
      if (w == resp) begin
        rv = Wid_bin'($urandom);
        if (ncalc == 63 && resp == 4 && !lock) rv = 16'h1234;
        u_if.pe_res_vld = 1'b1;
        u_if.pe_res     = rv;
      end
      tick();
      u_if.pe_res_vld = 1'b0;
      if (w == resp) begin
        answered = 1'b1;
        ref_result = rv;
        chk("done",     512'(done), 512'(1));
        chk("done_tmo", 512'(timeout), 512'(0));
        chk("result",   512'(result), 512'(ref_result));
        chk("done_rdy", 512'(start_rdy), 512'(1));
      end
    end
    if (!answered) begin
      chk("tmo",        512'(timeout), 512'(1));
      chk("tmo_done",   512'(done), 512'(0));
      chk("tmo_result", 512'(result), 512'(ref_result));
      chk("tmo_rdy",    512'(start_rdy), 512'(1));
    end
    tick();
    chk("post_flush", 512'(u_if.pe_flush), 512'(0));
    chk("post_done",  512'(done), 512'(0));
    chk("post_rdy",   512'(start_rdy), 512'(1));
    chk("hold_wsig",  512'(u_if.pe_Wsig_vec), 512'(ref_sig));
    chk("hold_wabs",  512'(u_if.pe_Wabs_vec), 512'(ref_abs));
    chk("hold_res",   512'(result), 512'(ref_result));
  endtask

  initial begin
    rst = 1'b1; act_wr_en = 1'b0; act_wr_addr = '0; act_wr_data = '0;
    start = 1'b0; start_ncalc = '0;
    wgt_sig_vec = '0; wgt_exp_vec = '0; wgt_abs_vec = '0;
    u_if.pe_res_vld = 1'b0; u_if.pe_res = '0;
    ref_result = '0;
    tick(); tick();
    chk_reset_state();
    rst = 1'b0;
    tick();

    fill(1'b0);
    run_job(63, 4, 1'b0, -1);          // full job, result 0x1234
    run_job(20, 1, 1'b0, -1);          // two beats
    run_job(5, -1, 1'b0, -1);          // watchdog expiry
    run_job(40, TMO - 1, 1'b0, -1);    // result on the expiry cycle

    u_if.pe_res_vld = 1'b1; u_if.pe_res = 16'hDEAD;
    tick();
    u_if.pe_res_vld = 1'b0;
    chk("idle_res_done", 512'(done), 512'(0));
    chk("idle_res_hold", 512'(result), 512'(ref_result));

    run_job(63, 2, 1'b1, -1);          // start/write during STREAM ignored
    run_job(10, 0, 1'b0, -1);          // beat 0 still carries original buf[5]

    run_job(63, 2, 1'b0, 2);           // reset during beat 2
    fill(1'b1);
    run_job(30, 3, 1'b0, -1);

    for (int j = 0; j < 12; j++) begin
      int resp;
      for (int n = 0; n < 4; n++) wr($urandom_range(0, NT - 1), Wid_bin'($urandom));
      resp = $urandom_range(0, TMO);
      run_job($urandom_range(0, NT - 1), (resp == TMO) ? -1 : resp, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
